adc_readout_arbiter: RTL and testbench
======================================

Name: adc_readout_arbiter

Overview:
- Shares the single 32-bit PS-bound ADC readout stream between N_CH ADC capture channels.
- Grants one channel at a time, with packet granularity, in round-robin or GPIO-selected manual mode.
- Prefixes every packet with a header word carrying the channel ID and a sequence number.
- Truncates runaway packets at MAX_WORDS. Sits between the per-channel ADC capture buffers and the adc_axis output in rfsoc_pl_ctrl, on the PS clock.

Parameters:
- N_CH, 16, number of ADC capture channels.
- CH_W, 4, channel index width; must satisfy 2^CH_W >= N_CH and CH_W <= 8.
- MAX_WORDS, 64, maximum data words per packet before forced termination.
- HDR_TAG, 8'hA5, constant placed in header bits [31:24].

Ports:
- ps_clk  in  1  sole clock.
- rst  in  1  synchronous active-high reset.
- enable  in  1  permits new grants.
- manual_mode  in  1  1 = only manual_sel may be granted.
- manual_sel  in  CH_W  channel used in manual mode.
- s_axis_tdata  in  N_CH*32  channel c occupies bits [c*32 +: 32].
- s_axis_tvalid  in  N_CH  per-channel valid.
- s_axis_tlast  in  N_CH  per-channel end of packet.
- s_axis_tready  out  N_CH  per-channel ready.
- adc_axis_tdata  out  32  merged stream to PS.
- adc_axis_tvalid  out  1  merged valid.
- adc_axis_tready  in  1  PS ready.
- adc_axis_tlast  out  1  end of packet.
- cur_chan  out  CH_W  granted channel (held after release).
- busy  out  1  high in HEADER or DATA.
- trunc_err  out  1  sticky, set on any forced termination.

Behaviour:
- Reset (rst=1 at a ps_clk edge) drives the following; reset mid-packet abandons the packet with no tlast emitted:
  - state=IDLE, all s_axis_tready=0, adc_axis_tvalid=0, adc_axis_tlast=0, adc_axis_tdata=0;
  - cur_chan=N_CH-1 (so the first round-robin pick starts at 0);
  - seq=0, word_cnt=0, busy=0, trunc_err=0.
- States: IDLE, HEADER, DATA.
- IDLE:
  - No ready or valid asserted.
  - If enable=1 and a candidate exists, register the grant: cur_chan<=winner, next state HEADER.
  - Round robin: winner is the first c with s_axis_tvalid[c]=1, searching cur_chan+1, cur_chan+2, ... modulo N_CH; cur_chan itself is checked last.
  - Manual: candidate only if s_axis_tvalid[manual_sel]=1. manual_sel >= N_CH never grants.
  - Latency: tvalid rising in cycle t gives header valid in cycle t+1.
- HEADER:
  - adc_axis_tvalid=1, adc_axis_tdata={HDR_TAG, zero-extended cur_chan to 8b, seq[15:0]}, adc_axis_tlast=0.
  - All s_axis_tready=0.
  - On adc_axis_tready=1: word_cnt<=0, next state DATA.
- DATA:
  - adc_axis_tdata/tvalid come from the granted channel combinationally.
  - s_axis_tready[cur_chan]=adc_axis_tready; all other readies 0.
  - adc_axis_tlast = s_axis_tlast[cur_chan] OR (word_cnt==MAX_WORDS-1).
  - Each transfer (tvalid & tready) increments word_cnt.
  - Transfer with adc_axis_tlast=1: seq<=seq+1 (wraps 16'hFFFF to 0), next state IDLE.
  - If the forced term caused tlast and the source tlast=0, set trunc_err; the source's remaining words are treated as a new packet at its next grant.
- enable deassert mid-packet: the current packet completes normally; no new grant until enable=1.
- Mode or manual_sel change mid-packet: ignored until IDLE.
- Back-to-back packets: at least 1 IDLE cycle between packets (arbitration cycle).
- busy = (state != IDLE).

Test Plan:
- Round robin: channels 0, 3, 7 each hold one 16-word packet (tlast on word 15), adc_axis_tready=1 → order ch0, ch3, ch7; headers 32'hA5000000, 32'hA5030001, 32'hA5070002; 17 words per packet; trunc_err=0.
- Fairness: ch2 and ch5 continuously valid, 2-word packets, 6 packets captured → grant sequence 2, 5, 2, 5, 2, 5.
- Manual: manual_mode=1, manual_sel=9, all channels valid → only ch9 granted; manual_sel=20 → no grant, busy stays 0.
- Backpressure: adc_axis_tready toggled 1,0,1,0 during DATA → data stable while stalled; no word dropped or duplicated; s_axis_tready[cur_chan] mirrors adc_axis_tready.
- Truncation: MAX_WORDS=4, ch1 sends 6 words without tlast → tlast forced on 4th data word; trunc_err=1; next ch1 grant carries the remaining 2 words under header seq+1.
- Reset mid-DATA after 3 words → next cycle tvalid=0, all readies 0, seq=0; next grant header 32'hA5000000 for ch0.

Source files
------------

// File: rtl/adc_readout_arbiter_if.sv
// Handshake bundle between the per-channel ADC capture streams and the merged PS stream.
// The master side is the arbiter; the slave side is the surrounding capture/PS logic.
interface adc_readout_arbiter_if #(
    parameter int N_CH = 16
);
    logic [N_CH*32-1:0] s_axis_tdata;
    logic [N_CH-1:0]    s_axis_tvalid;
    logic [N_CH-1:0]    s_axis_tlast;
    logic [N_CH-1:0]    s_axis_tready;
    logic [31:0]        adc_axis_tdata;
    logic               adc_axis_tvalid;
    logic               adc_axis_tready;
    logic               adc_axis_tlast;

    modport master (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, adc_axis_tready,
        output s_axis_tready, adc_axis_tdata, adc_axis_tvalid, adc_axis_tlast
    );

    modport slave (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, adc_axis_tready,
        input  s_axis_tready, adc_axis_tdata, adc_axis_tvalid, adc_axis_tlast
    );
endinterface

// File: rtl/adc_readout_arbiter.sv
// Packet-granular arbiter merging N_CH ADC capture streams onto one 32-bit PS stream,
// prefixing each packet with a {tag, channel, sequence} header and truncating runaway packets.
module adc_readout_arbiter #(
    parameter int          N_CH      = 16,
    parameter int          CH_W      = 4,
    parameter int          MAX_WORDS = 64,
    parameter logic [7:0]  HDR_TAG   = 8'hA5
) (
    input  logic            ps_clk,
    input  logic            rst,
    input  logic            enable,
    input  logic            manual_mode,
    input  logic [CH_W-1:0] manual_sel,
    adc_readout_arbiter_if.master bus,
    output logic [CH_W-1:0] cur_chan,
    output logic            busy,
    output logic            trunc_err
);
    localparam int N_EXT = 1 << CH_W;
    localparam int CNT_W = $clog2(MAX_WORDS + 1);

    typedef enum logic [1:0] {S_IDLE, S_HEADER, S_DATA} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CH_W-1:0]  r_cur_chan;
    logic [15:0]      r_seq;
    logic [CNT_W-1:0] r_word_cnt;
    logic             r_trunc_err;

    // Channel views padded to the full CH_W index range so any index is safe;
    // padding channels are never valid, so manual_sel >= N_CH can never win.
    logic [31:0]      w_ch_data [N_EXT];
    logic [N_EXT-1:0] w_valid_ext;
    logic [N_EXT-1:0] w_last_ext;

    genvar gi;
    generate
        for (gi = 0; gi < N_EXT; gi++) begin : g_ext
            if (gi < N_CH) begin : g_ch
                assign w_ch_data[gi]   = bus.s_axis_tdata[gi*32 +: 32];
                assign w_valid_ext[gi] = bus.s_axis_tvalid[gi];
                assign w_last_ext[gi]  = bus.s_axis_tlast[gi];
            end else begin : g_pad
                assign w_ch_data[gi]   = 32'd0;
                assign w_valid_ext[gi] = 1'b0;
                assign w_last_ext[gi]  = 1'b0;
            end
        end
    endgenerate

    // Round-robin search: walking offsets from far to near lets the nearest
    // requester after cur_chan overwrite the others; cur_chan itself is offset N_CH.
    logic            w_rr_found;
    logic [CH_W-1:0] w_rr_winner;
    logic [CH_W-1:0] w_rr_idx;

    always_comb begin
        w_rr_found  = 1'b0;
        w_rr_winner = '0;
        w_rr_idx    = '0;
        for (int k = N_CH; k >= 1; k--) begin
            w_rr_idx = CH_W'((int'(r_cur_chan) + k) % N_CH);
            if (w_valid_ext[w_rr_idx]) begin
                w_rr_found  = 1'b1;
                w_rr_winner = w_rr_idx;
            end
        end
    end

    logic             w_grant;
    logic [CH_W-1:0]  w_grant_chan;
    logic             w_tvalid;
    logic [31:0]      w_tdata;
    logic             w_tlast;
    logic [N_EXT-1:0] w_rdy_ext;
    logic             w_xfer;
    logic             w_forced;

    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_grant_chan = r_cur_chan;
        w_tvalid     = 1'b0;
        w_tdata      = 32'd0;
        w_tlast      = 1'b0;
        w_rdy_ext    = '0;
        w_xfer       = 1'b0;
        w_forced     = (r_word_cnt == CNT_W'(MAX_WORDS - 1));

        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    if (manual_mode) begin
                        if (w_valid_ext[manual_sel]) begin
                            w_grant      = 1'b1;
                            w_grant_chan = manual_sel;
                        end
                    end else if (w_rr_found) begin
                        w_grant      = 1'b1;
                        w_grant_chan = w_rr_winner;
                    end
                end
                if (w_grant) begin
                    w_state_next = S_HEADER;
                end
            end
            S_HEADER: begin
                w_tvalid = 1'b1;
                w_tdata  = {HDR_TAG, 8'(r_cur_chan), r_seq};
                if (bus.adc_axis_tready) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                w_tvalid              = w_valid_ext[r_cur_chan];
                w_tdata               = w_ch_data[r_cur_chan];
                w_tlast               = w_last_ext[r_cur_chan] | w_forced;
                w_rdy_ext[r_cur_chan] = bus.adc_axis_tready;
                w_xfer                = w_tvalid & bus.adc_axis_tready;
                if (w_xfer && w_tlast) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ps_clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cur_chan  <= CH_W'(N_CH - 1);
            r_seq       <= 16'd0;
            r_word_cnt  <= '0;
            r_trunc_err <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_grant) begin
                r_cur_chan <= w_grant_chan;
            end
            if (r_state == S_HEADER && bus.adc_axis_tready) begin
                r_word_cnt <= '0;
            end else if (w_xfer) begin
                r_word_cnt <= r_word_cnt + CNT_W'(1);
            end
            // Only a forced end without the source's own tlast counts as truncation.
            if (w_xfer && w_tlast) begin
                r_seq <= r_seq + 16'd1;
                if (w_forced && !w_last_ext[r_cur_chan]) begin
                    r_trunc_err <= 1'b1;
                end
            end
        end
    end

    assign bus.adc_axis_tdata  = w_tdata;
    assign bus.adc_axis_tvalid = w_tvalid;
    assign bus.adc_axis_tlast  = w_tlast;
    assign bus.s_axis_tready   = w_rdy_ext[N_CH-1:0];
    assign cur_chan            = r_cur_chan;
    assign busy                = (r_state != S_IDLE);
    assign trunc_err           = r_trunc_err;
endmodule

// File: tb/tb_adc_readout_arbiter.sv
// Scoreboard bench for adc_readout_arbiter: queued channel sources feed two instances
// (default depth and MAX_WORDS=4); a negedge monitor pops expected words and compares.
module tb_adc_readout_arbiter;
    localparam int N_CH = 16;
    localparam int CH_W = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic manual_mode = 1'b0;
    logic [CH_W-1:0] manual_sel = '0;
    logic [N_CH*32-1:0] src_tdata = '0;
    logic [N_CH-1:0] src_tvalid = '0;
    logic [N_CH-1:0] src_tlast = '0;
    logic m_tready = 1'b0;
    logic use_b = 1'b0;

    logic [CH_W-1:0] cur_a, cur_b;
    logic busy_a, busy_b, trunc_a, trunc_b;

    adc_readout_arbiter_if #(.N_CH(N_CH)) ifa ();
    adc_readout_arbiter_if #(.N_CH(N_CH)) ifb ();

    assign ifa.s_axis_tdata    = src_tdata;
    assign ifa.s_axis_tvalid   = src_tvalid;
    assign ifa.s_axis_tlast    = src_tlast;
    assign ifa.adc_axis_tready = m_tready;
    assign ifb.s_axis_tdata    = src_tdata;
    assign ifb.s_axis_tvalid   = src_tvalid;
    assign ifb.s_axis_tlast    = src_tlast;
    assign ifb.adc_axis_tready = m_tready;

    adc_readout_arbiter #(.N_CH(N_CH), .CH_W(CH_W)) dut_a (
        .ps_clk(clk), .rst(rst), .enable(enable), .manual_mode(manual_mode),
        .manual_sel(manual_sel), .bus(ifa), .cur_chan(cur_a), .busy(busy_a),
        .trunc_err(trunc_a)
    );

    adc_readout_arbiter #(.N_CH(N_CH), .CH_W(CH_W), .MAX_WORDS(4)) dut_b (
        .ps_clk(clk), .rst(rst), .enable(enable), .manual_mode(manual_mode),
        .manual_sel(manual_sel), .bus(ifb), .cur_chan(cur_b), .busy(busy_b),
        .trunc_err(trunc_b)
    );

    wire [N_CH-1:0] s_rdy    = use_b ? ifb.s_axis_tready : ifa.s_axis_tready;
    wire [31:0]     m_tdata  = use_b ? ifb.adc_axis_tdata : ifa.adc_axis_tdata;
    wire            m_tvalid = use_b ? ifb.adc_axis_tvalid : ifa.adc_axis_tvalid;
    wire            m_tlast  = use_b ? ifb.adc_axis_tlast : ifa.adc_axis_tlast;
    wire [CH_W-1:0] cur_s    = use_b ? cur_b : cur_a;
    wire            busy_s   = use_b ? busy_b : busy_a;
    wire            trunc_s  = use_b ? trunc_b : trunc_a;

    always #5 clk = ~clk;

    logic [32:0] src_q [N_CH][$];
    logic [32:0] sb [$];
    logic [N_CH-1:0] pend = '0;
    logic [15:0] exp_seq = 16'd0;
    int n_vec = 0;
    int n_err = 0;
    int mon_xfers = 0;
    bit toggle_en = 1'b0;
    bit bp_check = 1'b0;
    int bp_chan = 0;
    bit mon_in_data = 1'b0;
    bit stalled_prev = 1'b0;
    logic [31:0] stall_data = '0;
    logic [32:0] exp_word;
    logic [N_CH-1:0] exp_rdy;

    function automatic logic [31:0] dword(int ch, int p, int i);
        return {4'hD, 4'(p), 8'(ch), 16'(i)};
    endfunction

    function void refresh();
        for (int c = 0; c < N_CH; c++) begin
            if (src_q[c].size() > 0) begin
                src_tvalid[c]          = 1'b1;
                src_tlast[c]           = src_q[c][0][32];
                src_tdata[c*32 +: 32]  = src_q[c][0][31:0];
            end else begin
                src_tvalid[c]          = 1'b0;
                src_tlast[c]           = 1'b0;
                src_tdata[c*32 +: 32]  = 32'd0;
            end
        end
    endfunction

    // Sources advance just after the edge on which their word was accepted.
    always @(posedge clk) begin
        #1;
        for (int c = 0; c < N_CH; c++) begin
            if (pend[c] && src_q[c].size() > 0) void'(src_q[c].pop_front());
        end
        if (toggle_en) m_tready = ~m_tready;
        refresh();
    end

    // Monitor: handshakes are stable at the negedge, so the transfer about to happen is known here.
    always @(negedge clk) begin
        pend = '0;
        if (!rst) begin
            pend = src_tvalid & s_rdy;
            if (bp_check && mon_in_data) begin
                exp_rdy = m_tready ? (N_CH'(1) << bp_chan) : '0;
                n_vec++;
                if (s_rdy !== exp_rdy) begin
                    n_err++;
                    $display("FAIL ready_mirror: got %h expected %h", s_rdy, exp_rdy);
                end
            end
            if (stalled_prev && m_tvalid) begin
                n_vec++;
                if (m_tdata !== stall_data) begin
                    n_err++;
                    $display("FAIL stall_stable: got %h expected %h", m_tdata, stall_data);
                end
            end
            stalled_prev = m_tvalid && !m_tready;
            stall_data   = m_tdata;
            if (m_tvalid && m_tready) begin
                n_vec++;
                mon_xfers++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_word: got %b_%h expected none", m_tlast, m_tdata);
                end else begin
                    exp_word = sb.pop_front();
                    if ({m_tlast, m_tdata} !== exp_word) begin
                        n_err++;
                        $display("FAIL stream_word: got %b_%h expected %b_%h",
                                 m_tlast, m_tdata, exp_word[32], exp_word[31:0]);
                    end
                end
                mon_in_data = !m_tlast;
            end
        end else begin
            stalled_prev = 1'b0;
            mon_in_data  = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        for (int c = 0; c < N_CH; c++) src_q[c].delete();
        sb.delete();
        refresh();
        step();
        rst = 1'b0;
        exp_seq = 16'd0;
    endtask

    task automatic send_pkt(input int ch, input int p, input int n, input bit last_end);
        for (int i = 0; i < n; i++) src_q[ch].push_back({last_end && (i == n - 1), dword(ch, p, i)});
    endtask

    task automatic expect_hdr(input int ch);
        sb.push_back({1'b0, 8'hA5, 8'(ch), exp_seq});
        exp_seq = exp_seq + 16'd1;
    endtask

    task automatic expect_data(input int ch, input int p, input int first, input int last, input int tl_idx);
        for (int i = first; i <= last; i++) sb.push_back({i == tl_idx, dword(ch, p, i)});
    endtask

    task automatic wait_drain(input int budget, input bit need_idle, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (sb.size() == 0 && (!need_idle || !busy_s)) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        step();
        step();
        n_vec++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL rst_tvalid: got %b expected 0", m_tvalid); end
        n_vec++; if (m_tlast !== 1'b0) begin n_err++; $display("FAIL rst_tlast: got %b expected 0", m_tlast); end
        n_vec++; if (m_tdata !== 32'd0) begin n_err++; $display("FAIL rst_tdata: got %h expected 0", m_tdata); end
        n_vec++; if (s_rdy !== '0) begin n_err++; $display("FAIL rst_ready: got %h expected 0", s_rdy); end
        n_vec++; if (cur_s !== 5'd15) begin n_err++; $display("FAIL rst_cur_chan: got %0d expected 15", cur_s); end
        n_vec++; if (busy_s !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b expected 0", busy_s); end
        n_vec++; if (trunc_s !== 1'b0) begin n_err++; $display("FAIL rst_trunc: got %b expected 0", trunc_s); end
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        bit ok;
        int base;
        apply_reset();
        enable = 1'b1; manual_mode = 1'b0; m_tready = 1'b1;
        base = mon_xfers;
        send_pkt(0, 0, 16, 1'b1); send_pkt(3, 0, 16, 1'b1); send_pkt(7, 0, 16, 1'b1);
        refresh();
        expect_hdr(0); expect_data(0, 0, 0, 15, 15);
        expect_hdr(3); expect_data(3, 0, 0, 15, 15);
        expect_hdr(7); expect_data(7, 0, 0, 15, 15);
        wait_drain(400, 1'b1, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL rr_drain: got timeout expected drained, %0d left", sb.size()); end
        n_vec++; if (mon_xfers - base !== 51) begin n_err++; $display("FAIL rr_word_count: got %0d expected 51", mon_xfers - base); end
        n_vec++; if (trunc_s !== 1'b0) begin n_err++; $display("FAIL rr_trunc: got %b expected 0", trunc_s); end
    endtask

    task automatic test_fairness();
        bit ok;
        apply_reset();
        for (int p = 0; p < 3; p++) begin
            send_pkt(2, p, 2, 1'b1);
            send_pkt(5, p, 2, 1'b1);
        end
        refresh();
        for (int p = 0; p < 3; p++) begin
            expect_hdr(2); expect_data(2, p, 0, 1, 1);
            expect_hdr(5); expect_data(5, p, 0, 1, 1);
        end
        wait_drain(200, 1'b1, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL fair_drain: got timeout expected drained, %0d left", sb.size()); end
    endtask

    task automatic test_manual();
        bit ok;
        int busy_cycles;
        apply_reset();
        manual_mode = 1'b1; manual_sel = 5'd9;
        for (int c = 0; c < N_CH; c++) send_pkt(c, 0, 2, 1'b1);
        refresh();
        expect_hdr(9); expect_data(9, 0, 0, 1, 1);
        wait_drain(100, 1'b1, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL man_drain: got timeout expected drained, %0d left", sb.size()); end
        busy_cycles = 0;
        for (int i = 0; i < 10; i++) begin step(); if (busy_s) busy_cycles++; end
        n_vec++; if (busy_cycles !== 0) begin n_err++; $display("FAIL man_only_sel: got %0d busy cycles expected 0", busy_cycles); end
        manual_sel = 5'd20;
        busy_cycles = 0;
        for (int i = 0; i < 20; i++) begin step(); if (busy_s) busy_cycles++; end
        n_vec++; if (busy_cycles !== 0) begin n_err++; $display("FAIL man_sel_oob: got %0d busy cycles expected 0", busy_cycles); end
        n_vec++; if (cur_s !== 5'd9) begin n_err++; $display("FAIL man_cur_held: got %0d expected 9", cur_s); end
        manual_mode = 1'b0; manual_sel = '0;
    endtask

    task automatic test_backpressure();
        bit ok;
        apply_reset();
        bp_chan = 4; bp_check = 1'b1; toggle_en = 1'b1; m_tready = 1'b1;
        send_pkt(4, 0, 6, 1'b1);
        refresh();
        expect_hdr(4); expect_data(4, 0, 0, 5, 5);
        wait_drain(100, 1'b1, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL bp_drain: got timeout expected drained, %0d left", sb.size()); end
        bp_check = 1'b0; toggle_en = 1'b0; m_tready = 1'b1;
    endtask

    task automatic test_truncation();
        bit ok;
        use_b = 1'b1;
        apply_reset();
        send_pkt(1, 0, 6, 1'b0);
        refresh();
        expect_hdr(1); expect_data(1, 0, 0, 3, 3);
        expect_hdr(1); expect_data(1, 0, 4, 5, -1);
        wait_drain(100, 1'b0, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL trunc_drain: got timeout expected drained, %0d left", sb.size()); end
        n_vec++; if (trunc_s !== 1'b1) begin n_err++; $display("FAIL trunc_flag: got %b expected 1", trunc_s); end
        n_vec++; if (busy_s !== 1'b1) begin n_err++; $display("FAIL trunc_busy: got %b expected 1", busy_s); end
        apply_reset();
        use_b = 1'b0;
    endtask

    task automatic test_reset_mid_data();
        bit ok;
        int base;
        apply_reset();
        base = mon_xfers;
        send_pkt(0, 0, 8, 1'b1);
        refresh();
        expect_hdr(0); expect_data(0, 0, 0, 7, 7);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (mon_xfers - base == 4) begin ok = 1'b1; break; end
            step();
        end
        n_vec++; if (!ok) begin n_err++; $display("FAIL mid_progress: got %0d words expected 4", mon_xfers - base); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_vec++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL mid_tvalid: got %b expected 0", m_tvalid); end
        n_vec++; if (s_rdy !== '0) begin n_err++; $display("FAIL mid_ready: got %h expected 0", s_rdy); end
        n_vec++; if (busy_s !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %b expected 0", busy_s); end
        n_vec++; if (sb.size() !== 5) begin n_err++; $display("FAIL mid_abandoned: got %0d expected 5", sb.size()); end
        src_q[0].delete();
        sb.delete();
        exp_seq = 16'd0;
        send_pkt(0, 1, 2, 1'b1);
        refresh();
        expect_hdr(0); expect_data(0, 1, 0, 1, 1);
        wait_drain(100, 1'b1, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL mid_regrant: got timeout expected drained, %0d left", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_fairness();
        test_manual();
        test_backpressure();
        test_truncation();
        test_reset_mid_data();
        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
